// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: sequential load/store unit driving a req/gnt/rvalid data-memory port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_bus_ctrl #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      load_store_type_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] write_data_i,
  output logic            done_o,
  output logic [XLEN-1:0] read_data_o,
  output logic            misaligned_o,
  output logic            access_fault_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int TW  = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [3:0] L_B = 4'd0, L_BU = 4'd1, L_H = 4'd2, L_HU = 4'd3, L_W = 4'd4;
  localparam logic [3:0] S_B = 4'd5, S_H = 4'd6, S_W = 4'd7;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e          state, state_d;
  logic [3:0]      typ_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [TW-1:0]   cnt;
  logic            fault_q, mis_q;
  logic            accept, busy, tmo;
  logic            in_ls, in_h, in_w, mis_in, trap;
  logic [XLEN-1:0] addr_al;
  logic            q_h, q_w, q_ld, q_st;
  logic [OFS-1:0]  ofs;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wsh, wmask, sh, ext;

  assign in_ls   = load_store_type_i <= S_W;
  assign in_h    = load_store_type_i == L_H || load_store_type_i == L_HU || load_store_type_i == S_H;
  assign in_w    = load_store_type_i == L_W || load_store_type_i == S_W;
  assign mis_in  = (in_h & addr_i[0]) | (in_w & |addr_i[1:0]);
  assign addr_al = addr_i & ~XLEN'(in_w ? 2'b11 : {1'b0, in_h});
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = in_ls & mis_in;
`else
  assign trap = 1'b0;
`endif

  assign accept = state == IDLE && req_valid_i;
  assign busy   = state == REQ || state == WAIT;
  assign tmo    = TIMEOUT_CYC != 0 && busy && cnt == TW'(TIMEOUT_CYC - 1);

  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = req_valid_i ? ((in_ls && !trap) ? REQ : RESP) : IDLE;
      REQ:  state_d = tmo ? RESP : mem_gnt_i ? WAIT : REQ;
      WAIT: state_d = (tmo || mem_rvalid_i) ? RESP : WAIT;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      typ_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
      fault_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        typ_q   <= load_store_type_i;
        addr_q  <= addr_al;
        wdata_q <= write_data_i;
        rdata_q <= '0;
        cnt     <= '0;
        fault_q <= 1'b0;
        mis_q   <= trap;
      end
      if (busy) cnt <= cnt + TW'(1);
      if (tmo) fault_q <= 1'b1;
      if (state == WAIT && mem_rvalid_i && !tmo) rdata_q <= mem_rdata_i;
    end
  end

  assign q_h  = typ_q == L_H || typ_q == L_HU || typ_q == S_H;
  assign q_w  = typ_q == L_W || typ_q == S_W;
  assign q_ld = typ_q <= L_W;
  assign q_st = typ_q == S_B || typ_q == S_H || typ_q == S_W;
  assign ofs  = addr_q[OFS-1:0];
  assign be   = NB'(q_w ? 4'hF : q_h ? 4'h3 : 4'h1) << ofs;
  assign wsh  = wdata_q << {ofs, 3'b000};
  assign sh   = rdata_q >> {ofs, 3'b000};

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{be[i]}};
  end

  assign ext = typ_q == L_B  ? XLEN'($signed(sh[7:0])) :
               typ_q == L_BU ? XLEN'(sh[7:0]) :
               typ_q == L_H  ? XLEN'($signed(sh[15:0])) :
               typ_q == L_HU ? XLEN'(sh[15:0]) :
                               XLEN'($signed(sh[31:0]));

  assign req_ready_o    = state == IDLE;
  assign done_o         = state == RESP;
  assign mem_req_o      = state == REQ;
  assign mem_we_o       = mem_req_o & q_st;
  assign mem_addr_o     = mem_req_o ? {addr_q[XLEN-1:OFS], {OFS{1'b0}}} : '0;
  assign mem_be_o       = mem_req_o ? be : '0;
  assign mem_wdata_o    = mem_req_o ? (wsh & wmask) : '0;
  assign misaligned_o   = done_o & mis_q;
  assign access_fault_o = done_o & fault_q;
  assign read_data_o    = (done_o && q_ld && !fault_q && !mis_q) ? ext : '0;
endmodule
